sec_ded_pipe_decoder: RTL and testbench
=======================================

SEC_DED_PIPE_DECODER -- requirements
Module: sec_ded_pipe_decoder

Interface
REQ-001 Parameter DATA_W, default 32, data bits per codeword (4..256).
REQ-002 Parameter CNT_W, default 16, width of each error counter.
REQ-003 Derived R = smallest integer with 2^R >= DATA_W+R+1; CHK_W = R+1 (DATA_W=32 gives R=6, CHK_W=7).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  decoder accepts beat.
REQ-008 in_data  in  DATA_W  received data bits.
REQ-009 in_chk  in  CHK_W  received check bits; [R-1:0] Hamming, [R] overall parity.
REQ-010 corr_en  in  1  correction enable, sampled with the beat.
REQ-011 out_valid  out  1  output beat valid.
REQ-012 out_ready  in  1  downstream accepts beat.
REQ-013 out_data  out  DATA_W  corrected (or passed-through) data.
REQ-014 out_syn  out  R  Hamming syndrome of the beat.
REQ-015 out_ce  out  1  single (correctable) error detected.
REQ-016 out_ue  out  1  double (uncorrectable) error detected.
REQ-017 cnt_clr  in  1  synchronous counter clear.
REQ-018 cnt_ce  out  CNT_W  count of single-error beats delivered.
REQ-019 cnt_ue  out  CNT_W  count of double-error beats delivered.

Function
REQ-020 Codeword positions 1..DATA_W+R; position 2^i holds in_chk[i]; data bits fill the remaining positions ascending, in_data[0] at position 3.
REQ-021 Syndrome = XOR of position indices of all set bits among positions 1..DATA_W+R.
REQ-022 Parity fault = XOR of in_data, in_chk[R-1:0] and in_chk[R] equals 1.
REQ-023 Classify: syn=0, no fault -> clean; fault -> single (out_ce=1); syn!=0, no fault -> double (out_ue=1); single and double never both 1.
REQ-024 Single with syn mapping to a data position and corr_en=1 -> that data bit inverted in out_data; otherwise out_data = in_data.
REQ-025 Single with syn=0, syn at a check position, or syn > DATA_W+R -> data unchanged, out_ce=1 (syn > DATA_W+R still reported as single).
REQ-026 corr_en=0 -> out_data = in_data always; flags, syndrome and counters unaffected by corr_en.
REQ-027 Two-stage pipeline: stage 1 registers data, syndrome, parity fault, corr_en; stage 2 registers corrected data and flags.
REQ-028 Latency exactly 2 cycles from input handshake to out_valid when out_ready held 1; throughput 1 beat/cycle.
REQ-029 Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-030 Stage advances when next stage empty or next stage transferring this cycle; in_ready = !s1_valid | stage-1 advancing (no combinational path in_valid->in_ready).
REQ-031 While out_valid=1 and out_ready=0, out_data/out_syn/out_ce/out_ue stay stable; max 2 beats buffered.
REQ-032 Counters increment on output handshake of a flagged beat, saturating at 2^CNT_W-1.
REQ-033 cnt_clr=1 zeroes both counters next edge; clear wins over a simultaneous increment.
REQ-034 No beat dropped, duplicated or reordered.

Reset
REQ-035 rst_n low: stage valids, out_valid, out_ce, out_ue, cnt_ce, cnt_ue -> 0 immediately; out_data, out_syn -> 0.
REQ-036 in_ready = 1 during and after reset.
REQ-037 Reset mid-stream discards all buffered beats; first beat after release has latency 2.

Verification
REQ-038 DATA_W=32, in_data=0, in_chk=0, corr_en=1 -> 2 cycles later out_data=0, syn=0, ce=0, ue=0.
REQ-039 in_data=0x00000001, in_chk=0 (data bit 0 flipped) -> syn=3, ce=1, out_data=0, cnt_ce=1.
REQ-040 Same beat with corr_en=0 -> out_data=0x00000001, syn=3, ce=1.
REQ-041 in_data=0x00000003, in_chk=0 (two flips) -> syn=3^5=6, ue=1, out_data=0x00000003, cnt_ue=1.
REQ-042 out_ready=0 for 5 cycles, in_valid=1 -> exactly 2 beats accepted, in_ready=0 thereafter, order preserved on release.
REQ-043 CNT_W=2, 5 single-error beats -> cnt_ce=3; cnt_clr with concurrent flagged beat -> cnt_ce=0.

Source files
------------

// File: rtl/sec_ded_pipe_decoder.sv
// Two-stage pipelined SEC-DED (extended Hamming) decoder with valid/ready
// handshaking and saturating single/double error counters.
module sec_ded_pipe_decoder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned R     = (DATA_W <= 4)   ? 3 :
                                  (DATA_W <= 11)  ? 4 :
                                  (DATA_W <= 26)  ? 5 :
                                  (DATA_W <= 57)  ? 6 :
                                  (DATA_W <= 120) ? 7 :
                                  (DATA_W <= 247) ? 8 : 9,
  localparam int unsigned CHK_W = R + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              corr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [R-1:0]      out_syn,
  output logic              out_ce,
  output logic              out_ue,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_ce,
  output logic [CNT_W-1:0]  cnt_ue
);

  localparam int unsigned N = DATA_W + R;

  // Codeword position of data bit idx: data fills non-power-of-two slots from 3 up.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned d;
    d        = 0;
    data_pos = 0;
    for (int unsigned p = 3; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d == idx) data_pos = p;
        d++;
      end
    end
  endfunction

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [R-1:0]      s1_syn;
  logic              s1_fault;
  logic              s1_corr;

  logic [R-1:0]      syn_c;
  logic              fault_c;
  logic [DATA_W-1:0] s2_data_c;
  logic              s2_ce_c;
  logic              s2_ue_c;
  logic              s2_adv_c;
  logic              out_hs_c;

  // Stage 2 can take a new beat when empty or emptying this cycle.
  assign s2_adv_c = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv_c;
  assign out_hs_c = out_valid && out_ready;

  // Syndrome and overall parity of the incoming codeword.
  always_comb begin
    syn_c = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (in_data[i]) syn_c = syn_c ^ R'(data_pos(i));
    end
    for (int unsigned i = 0; i < R; i++) begin
      if (in_chk[i]) syn_c = syn_c ^ R'(32'd1 << i);
    end
    fault_c = ^{in_data, in_chk};
  end

  // Stage 1 capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_fault <= 1'b0;
      s1_corr  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data  <= in_data;
        s1_syn   <= syn_c;
        s1_fault <= fault_c;
        s1_corr  <= corr_en;
      end
    end
  end

  // Classification and single-bit correction of the stage 1 beat.
  always_comb begin
    s2_ce_c   = s1_fault;
    s2_ue_c   = !s1_fault && (s1_syn != '0);
    s2_data_c = s1_data;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (s1_fault && s1_corr && (s1_syn == R'(data_pos(i)))) begin
        s2_data_c[i] = ~s1_data[i];
      end
    end
  end

  // Stage 2 output register; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_syn   <= '0;
      out_ce    <= 1'b0;
      out_ue    <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_data_c;
        out_syn  <= s1_syn;
        out_ce   <= s2_ce_c;
        out_ue   <= s2_ue_c;
      end
    end
  end

  // Saturating error counters; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ce <= '0;
      cnt_ue <= '0;
    end else if (cnt_clr) begin
      cnt_ce <= '0;
      cnt_ue <= '0;
    end else if (out_hs_c) begin
      if (out_ce && (cnt_ce != {CNT_W{1'b1}})) cnt_ce <= cnt_ce + CNT_W'(1);
      if (out_ue && (cnt_ue != {CNT_W{1'b1}})) cnt_ue <= cnt_ue + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sec_ded_pipe_decoder.sv
// Scoreboard bench for sec_ded_pipe_decoder (DATA_W=32, CNT_W=2).
module tb_sec_ded_pipe_decoder;

  typedef struct packed {
    logic [31:0] d;
    logic [5:0]  s;
    logic        ce;
    logic        ue;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [6:0]  in_chk;
  logic        corr_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_syn;
  logic        out_ce;
  logic        out_ue;
  logic        cnt_clr;
  logic [1:0]  cnt_ce;
  logic [1:0]  cnt_ue;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  sec_ded_pipe_decoder #(.DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk(in_chk),
    .corr_en(corr_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_syn(out_syn),
    .out_ce(out_ce), .out_ue(out_ue),
    .cnt_clr(cnt_clr), .cnt_ce(cnt_ce), .cnt_ue(cnt_ue)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every delivered beat against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %h expected no beat", out_data);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", out_data, mon_e.d);
        check("out_syn", 32'(out_syn), 32'(mon_e.s));
        check("out_ce", 32'(out_ce), 32'(mon_e.ce));
        check("out_ue", 32'(out_ue), 32'(mon_e.ue));
      end
    end
  end

  // Drive one beat until accepted; expected response is queued at the handshake.
  task automatic send(input logic [31:0] d, input logic [6:0] c, input logic ce_en,
                      input logic [31:0] ed, input logic [5:0] es, input logic ece, input logic eue);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_chk   = c;
    corr_en  = ce_en;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{d: ed, s: es, ce: ece, ue: eue});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 20 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 50 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Called right after a beat is accepted into an empty pipeline.
  task automatic lat_check(input string name);
    @(negedge clk);
    check({name, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_lat2"}, 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] st_d [3] = '{32'h1, 32'h3, 32'h11};
  logic [6:0]  st_c [3] = '{7'h43, 7'h00, 7'h43};
  logic [31:0] st_ed[3] = '{32'h1, 32'h3, 32'h1};
  logic [5:0]  st_es[3] = '{6'd0, 6'd6, 6'd9};
  logic        st_ce[3] = '{1'b0, 1'b0, 1'b1};
  logic        st_ue[3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int t0;
    int acc;
    int idx;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_chk    = '0;
    corr_en   = 1'b1;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", out_data, 32'd0);
    check("rst_cnt_ce", 32'(cnt_ce), 32'd0);
    check("rst_cnt_ue", 32'(cnt_ue), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clean all-zero codeword, with latency check.
    send(32'h0, 7'h00, 1'b1, 32'h0, 6'd0, 1'b0, 1'b0);
    lat_check("clean");
    wait_drain();

    // Data bit 0 flipped, corrected.
    send(32'h1, 7'h00, 1'b1, 32'h0, 6'd3, 1'b1, 1'b0);
    wait_drain();
    check("cnt_ce_1", 32'(cnt_ce), 32'd1);

    // Same beat with correction disabled.
    send(32'h1, 7'h00, 1'b0, 32'h1, 6'd3, 1'b1, 1'b0);
    wait_drain();
    check("cnt_ce_2", 32'(cnt_ce), 32'd2);

    // Two data bits flipped.
    send(32'h3, 7'h00, 1'b1, 32'h3, 6'd6, 1'b0, 1'b1);
    wait_drain();
    check("cnt_ue_1", 32'(cnt_ue), 32'd1);

    // Back-to-back burst: check bit, overall parity, top data bit, syn>N, clean, corrected.
    t0 = cyc;
    send(32'h0,        7'h01, 1'b1, 32'h0, 6'd1,  1'b1, 1'b0);
    send(32'h0,        7'h40, 1'b1, 32'h0, 6'd0,  1'b1, 1'b0);
    send(32'h80000000, 7'h00, 1'b1, 32'h0, 6'd38, 1'b1, 1'b0);
    send(32'h0,        7'h7F, 1'b1, 32'h0, 6'd63, 1'b1, 1'b0);
    send(32'h1,        7'h43, 1'b1, 32'h1, 6'd0,  1'b0, 1'b0);
    send(32'h11,       7'h43, 1'b1, 32'h1, 6'd9,  1'b1, 1'b0);
    send(32'h1,        7'h00, 1'b1, 32'h0, 6'd3,  1'b1, 1'b0);
    check("burst_cycles", 32'(cyc - t0), 32'd7);
    wait_drain();
    check("cnt_ce_sat", 32'(cnt_ce), 32'd3);
    check("cnt_ue_keep", 32'(cnt_ue), 32'd1);

    // Clear coinciding with a flagged output handshake.
    send(32'h1, 7'h00, 1'b1, 32'h0, 6'd3, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    wait_drain();
    check("clr_cnt_ce", 32'(cnt_ce), 32'd0);
    check("clr_cnt_ue", 32'(cnt_ue), 32'd0);

    // Output stall: exactly two beats buffered, order kept on release.
    out_ready = 1'b0;
    acc = 0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = st_d[idx];
      in_chk   = st_c[idx];
      corr_en  = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{d: st_ed[idx], s: st_es[idx], ce: st_ce[idx], ue: st_ue[idx]});
        idx++;
        acc++;
      end
      @(posedge clk);
      #1;
    end
    check("stall_accepted", 32'(acc), 32'd2);
    @(negedge clk);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_out_data", out_data, st_ed[0]);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(st_d[2], st_c[2], 1'b1, st_ed[2], st_es[2], st_ce[2], st_ue[2]);
    wait_drain();
    check("stall_cnt_ce", 32'(cnt_ce), 32'd1);
    check("stall_cnt_ue", 32'(cnt_ue), 32'd1);

    // Reset mid-stream discards buffered beats.
    out_ready = 1'b0;
    send(32'h0, 7'h00, 1'b1, 32'h0, 6'd0, 1'b0, 1'b0);
    send(32'h3, 7'h00, 1'b1, 32'h3, 6'd6, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_cnt_ce", 32'(cnt_ce), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(32'h3, 7'h00, 1'b1, 32'h3, 6'd6, 1'b0, 1'b1);
    lat_check("post_rst");
    wait_drain();
    check("post_rst_cnt_ue", 32'(cnt_ue), 32'd1);
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
